// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - branch class encodings, condition codes and NZCV bit positions
package branch_pkg;

    localparam logic [1:0] BR_TYPE_B     = 2'b00;
    localparam logic [1:0] BR_TYPE_CBZ   = 2'b01;
    localparam logic [1:0] BR_TYPE_CBNZ  = 2'b10;
    localparam logic [1:0] BR_TYPE_BCOND = 2'b11;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam int NZCV_N = 3;
    localparam int NZCV_Z = 2;
    localparam int NZCV_C = 1;
    localparam int NZCV_V = 0;

endpackage

// File: rtl/branch_resolve_unit_cond_eval.sv
// rtl/branch_resolve_unit_cond_eval.sv - combinational B.cond evaluation against an NZCV value
module cond_eval
    import branch_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       cond_true
);

    logic n, z, c, v;

    assign n = nzcv[NZCV_N];
    assign z = nzcv[NZCV_Z];
    assign c = nzcv[NZCV_C];
    assign v = nzcv[NZCV_V];

    always_comb begin
        cond_true = 1'b1;
        case (cond)
            COND_EQ: cond_true = z;
            COND_NE: cond_true = !z;
            COND_CS: cond_true = c;
            COND_CC: cond_true = !c;
            COND_MI: cond_true = n;
            COND_PL: cond_true = !n;
            COND_VS: cond_true = v;
            COND_VC: cond_true = !v;
            COND_HI: cond_true = c && !z;
            COND_LS: cond_true = !(c && !z);
            COND_GE: cond_true = (n == v);
            COND_LT: cond_true = (n != v);
            COND_GT: cond_true = !z && (n == v);
            COND_LE: cond_true = !(!z && (n == v));
            COND_AL, COND_NV: cond_true = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - EX-stage branch resolution, NZCV register, redirect and front-end flush
// Optional statistics counters: define BRANCH_RESOLVE_STATS_EN.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int ADDR_W       = 64,
    parameter int FLUSH_CYCLES = 2
`ifdef BRANCH_RESOLVE_STATS_EN
    ,
    parameter int STAT_W       = 16
`endif
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              stall,
    input  logic              flags_we,
    input  logic [3:0]        alu_flags,
    input  logic              br_valid,
    input  logic [1:0]        br_type,
    input  logic [3:0]        br_cond,
    input  logic              reg_zero,
    input  logic              br_pred_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic [ADDR_W-1:0] br_fallthru,
    output logic              take_branch,
    output logic              redirect,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              flush,
    output logic [3:0]        flags_q
`ifdef BRANCH_RESOLVE_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispredicts
`endif
);

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

    logic [3:0] effFlags;
    logic [3:0] flushCnt;
    logic       condTrue;
    logic       outcome;
    logic       accept;
    logic       mispredict;

    // A flag-setter in the same EX slot is older than the branch, so it wins over flags_q.
    assign effFlags = flags_we ? alu_flags : flags_q;

    cond_eval uCondEval (
        .cond      (br_cond),
        .nzcv      (effFlags),
        .cond_true (condTrue)
    );

    always_comb begin
        outcome = 1'b1;
        case (br_type)
            BR_TYPE_B:     outcome = 1'b1;
            BR_TYPE_CBZ:   outcome = reg_zero;
            BR_TYPE_CBNZ:  outcome = !reg_zero;
            BR_TYPE_BCOND: outcome = condTrue;
        endcase
    end

    // Branches seen during flush are on the wrong path and must not touch any state.
    assign accept     = br_valid && !stall && !flush;
    assign mispredict = accept && (outcome != br_pred_taken);
    assign flush      = (flushCnt != 4'd0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_q     <= 4'd0;
            take_branch <= 1'b0;
            redirect    <= 1'b0;
            redirect_pc <= '0;
            flushCnt    <= 4'd0;
        end else if (!stall) begin
            if (flags_we) begin
                flags_q <= alu_flags;
            end
            redirect <= mispredict;
            if (accept) begin
                take_branch <= outcome;
            end
            if (mispredict) begin
                redirect_pc <= outcome ? br_target : br_fallthru;
                flushCnt    <= FLUSH_LOAD;
            end else if (flushCnt != 4'd0) begin
                flushCnt <= flushCnt - 4'd1;
            end
        end
    end

`ifdef BRANCH_RESOLVE_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (accept && (stat_branches != '1)) begin
                stat_branches <= stat_branches + 1'b1;
            end
            if (mispredict && (stat_mispredicts != '1)) begin
                stat_mispredicts <= stat_mispredicts + 1'b1;
            end
        end
    end
`endif

endmodule
